// File: rtl/add_pkg.sv
// Shared defaults and stage payload layout for the pipelined adder.
package add_pkg;

  localparam int unsigned ADD_WIDTH  = 4;
  localparam int unsigned ADD_STAGES = 2;
  localparam int unsigned ADD_CNT_W  = 16;

  // Payload at the default width; modules with a different WIDTH redeclare it locally.
  typedef struct packed {
    logic                 valid;
    logic [ADD_WIDTH:0]   res;
  } add_stage_t;

endpackage

// File: rtl/add_pipe_stage.sv
// One valid/result register stage; loads whenever it is empty or downstream takes its content.
module add_pipe_stage
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           up_valid_i,
  input  logic [WIDTH:0] up_res_i,
  input  logic           down_ready_i,
  output logic           valid_o,
  output logic [WIDTH:0] res_o
);

  typedef struct packed {
    logic           valid;
    logic [WIDTH:0] res;
  } stage_t;

  stage_t st_q, st_d;
  logic   load;

  // The result field only changes on a real load so y stays put while stalled.
  always_comb begin
    st_d = st_q;
    load = !st_q.valid || down_ready_i;
    if (load) begin
      st_d.valid = up_valid_i;
      if (up_valid_i) begin
        st_d.res = up_res_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign valid_o = st_q.valid;
  assign res_o   = st_q.res;

endmodule

// File: rtl/add_pipe.sv
// Pipelined unsigned adder with valid/ready on both sides and a completed-transaction counter.
// Optional subtract port and operation enabled by defining ADD_PIPE_SUB_EN.
module add_pipe
  import add_pkg::*;
#(
  parameter int unsigned WIDTH  = ADD_WIDTH,
  parameter int unsigned STAGES = ADD_STAGES,
  parameter int unsigned CNT_W  = ADD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADD_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic [CNT_W-1:0] txn_count
);

  logic [STAGES-1:0] vld;
  logic [WIDTH:0]    res [STAGES];
  logic [STAGES:0]   rdy;
  logic [WIDTH:0]    sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
`ifdef ADD_PIPE_SUB_EN
    sum = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
`else
    sum = {1'b0, a} + {1'b0, b};
`endif
  end

  // Ready ripples back from the consumer in one block so the chain is not split across instances.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[STAGES-1-i] = !vld[STAGES-1-i] || rdy[STAGES-i];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic           up_valid;
    logic [WIDTH:0] up_res;
    if (k == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_res   = sum;
    end else begin : g_rest
      assign up_valid = vld[k-1];
      assign up_res   = res[k-1];
    end
    add_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i       (clk),
      .rst_i       (rst),
      .up_valid_i  (up_valid),
      .up_res_i    (up_res),
      .down_ready_i(rdy[k+1]),
      .valid_o     (vld[k]),
      .res_o       (res[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign y         = res[STAGES-1];
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: vector table plus backpressure, reset and counter-wrap sequences.
module tb_add_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_ready_w;
  logic          out_valid, out_valid_w, out_ready;
  logic [W-1:0]  a, b;
  logic [W:0]    y, y_w;
  logic [15:0]   cnt;
  logic [1:0]    cnt_w;
`ifdef ADD_PIPE_SUB_EN
  logic          sub;
`endif

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef ADD_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .txn_count(cnt)
  );

  add_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
`ifdef ADD_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_w), .out_ready(out_ready), .y(y_w), .txn_count(cnt_w)
  );

  typedef struct {
    logic [W:0]  exp;
    int unsigned acc;
  } sb_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W:0]   exp;
  } vec_t;

  sb_t         sbq[$];
  vec_t        tbl[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned model_cnt = 0;
  logic [W:0]  cur_exp;
  bit          lat_chk;
  bit          acc_last;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    int unsigned exp_rdy;
    acc_last = 1'b0;
    if (rst) begin
      sbq.delete();
      model_cnt = 0;
    end else begin
      exp_rdy = (sbq.size() < S || out_ready) ? 1 : 0;
      chk("txn_count", cnt, model_cnt % 65536);
      chk("txn_count_w2", cnt_w, model_cnt % 4);
      chk("in_ready", in_ready, exp_rdy);
      chk("in_ready_w2", in_ready_w, exp_rdy);
      if (out_valid_w && sbq.size() > 0) chk("y_w2", y_w, sbq[0].exp);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("y", y, sbq[0].exp);
          if (out_ready) begin
            if (lat_chk) chk("latency", cyc - sbq[0].acc, S);
            void'(sbq.pop_front());
            model_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{cur_exp, cyc});
        acc_last = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    #4;
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                       input logic [W:0] ve);
    a        = va;
    b        = vb;
`ifdef ADD_PIPE_SUB_EN
    sub      = vs;
`else
    if (vs) chk("sub_vector_without_sub_port", 1, 0);
`endif
    cur_exp  = ve;
    in_valid = 1'b1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cur_exp = '0;
`ifdef ADD_PIPE_SUB_EN
    sub = 1'b0;
`endif
    lat_chk = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_txn_count", cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    tbl.push_back('{4'd1,  4'd3,  1'b0, 5'd4});
    tbl.push_back('{4'd5,  4'd6,  1'b0, 5'd11});
    tbl.push_back('{4'd7,  4'd8,  1'b0, 5'd15});
    tbl.push_back('{4'd15, 4'd15, 1'b0, 5'd30});
    tbl.push_back('{4'd0,  4'd0,  1'b0, 5'd0});
    tbl.push_back('{4'd15, 4'd0,  1'b0, 5'd15});
    tbl.push_back('{4'd8,  4'd8,  1'b0, 5'd16});
    tbl.push_back('{4'd9,  4'd4,  1'b0, 5'd13});
`ifdef ADD_PIPE_SUB_EN
    tbl.push_back('{4'd5,  4'd6,  1'b1, 5'd31});
    tbl.push_back('{4'd9,  4'd4,  1'b1, 5'd5});
    tbl.push_back('{4'd0,  4'd15, 1'b1, 5'd17});
    tbl.push_back('{4'd3,  4'd3,  1'b0, 5'd6});
`endif

    lat_chk   = 1'b1;
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      offer(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].exp);
      tick();
      chk("table_accept", acc_last, 1);
    end
    drain();
    lat_chk = 1'b0;
    chk("txn_after_table", cnt, tbl.size());

    // Backpressure: two accepts fill the pipe, then the third operand waits.
    out_ready = 1'b0;
    offer(4'd2, 4'd2, 1'b0, 5'd4);
    tick();
    chk("bp_accept1", acc_last, 1);
    offer(4'd3, 4'd3, 1'b0, 5'd6);
    tick();
    chk("bp_accept2", acc_last, 1);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_y_held", y, 4);
    offer(4'd4, 4'd4, 1'b0, 5'd8);
    tick();
    chk("bp_reject3", acc_last, 0);
    tick();
    chk("bp_y_still", y, 4);
    out_ready = 1'b1;
    tick();
    chk("bp_simul_accept", acc_last, 1);
    drain();

    // Reset with two results in flight: neither may ever emerge.
    out_ready = 1'b0;
    offer(4'd10, 4'd1, 1'b0, 5'd11);
    tick();
    offer(4'd12, 4'd2, 1'b0, 5'd14);
    tick();
    chk("mid_full", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_txn", cnt, 0);
    chk("mid_rst_txn_w2", cnt_w, 0);
    for (int i = 0; i < 5; i++) tick();

    // Counter wrap on the 2-bit instance: 1, 2, 3, 0, 1.
    for (int i = 0; i < 5; i++) begin
      offer(4'(i), 4'd1, 1'b0, 5'(i + 1));
      tick();
    end
    drain();
    chk("wrap_final_w2", cnt_w, 1);
    chk("wrap_final", cnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
